// File: rtl/gb_ppu_pkg.sv
// Shared PPU/OAM definitions: DMA FSM states and the fixed OAM/DMA register map.
package gb_ppu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int          OAM_BYTES    = 160;
  localparam logic [7:0]  OAM_LAST_IDX = 8'(OAM_BYTES - 1);

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine (FF46) plus the OAM port arbiter between DMA, PPU and CPU.
module oam_dma_ctrl
  import gb_ppu_pkg::*;
#(
  parameter int CYCLES_PER_BYTE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mmio_a,
  input  logic [7:0]  mmio_din,
  input  logic        mmio_wr,
  output logic [7:0]  mmio_dout,
  output logic [15:0] src_a,
  output logic        src_rd,
  input  logic [7:0]  src_dout,
  input  logic        ppu_oam_req,
  input  logic [15:0] ppu_oam_a,
  output logic        ppu_oam_gnt,
  input  logic [15:0] cpu_oam_a,
  input  logic [7:0]  cpu_oam_din,
  input  logic        cpu_oam_wr,
  output logic [7:0]  cpu_oam_dout,
  output logic [15:0] oam_a,
  output logic [7:0]  oam_din,
  output logic        oam_wr,
  input  logic [7:0]  oam_dout,
  output logic        dma_active
);

  localparam logic [3:0] CNT_LAST = 4'(CYCLES_PER_BYTE - 1);

  dma_state_t state, state_nxt;
  logic [7:0] dma, dma_nxt;
  logic [7:0] idx, idx_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic       reg_wr;
  logic       dma_wr;
  logic [7:0] src_hi;

  assign reg_wr = mmio_wr && (mmio_a == DMA_REG_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dma   <= 8'h00;
      idx   <= 8'h00;
      cnt   <= 4'h0;
    end else begin
      state <= state_nxt;
      dma   <= dma_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dma_nxt   = dma;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    case (state)
      IDLE: ;
      START: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = 4'h0;
          state_nxt = XFER;
        end else begin
          cnt_nxt = cnt + 4'h1;
        end
      end
      XFER: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = 4'h0;
          if (idx == OAM_LAST_IDX) state_nxt = IDLE;
          else                     idx_nxt   = idx + 8'h01;
        end else begin
          cnt_nxt = cnt + 4'h1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A register write restarts the transfer even on the final byte.
    if (reg_wr) begin
      dma_nxt   = mmio_din;
      idx_nxt   = 8'h00;
      cnt_nxt   = 4'h0;
      state_nxt = START;
    end
  end

  assign dma_active = (state == START) || (state == XFER);
  assign src_rd     = (state == XFER) && (cnt == 4'h0);
  assign dma_wr     = (state == XFER) && (cnt == 4'h1);
  // Pages E0-FF are echo RAM and alias down to C0-DF.
  assign src_hi     = (dma >= 8'hE0) ? (dma - 8'h20) : dma;
  assign src_a      = src_rd ? {src_hi, idx} : 16'hFFFF;
  assign mmio_dout  = (mmio_a == DMA_REG_ADDR && !mmio_wr) ? dma : 8'h00;
  assign ppu_oam_gnt = ppu_oam_req && !dma_active;

  always_comb begin
    oam_a        = 16'hFFFF;
    oam_din      = 8'h00;
    oam_wr       = 1'b0;
    cpu_oam_dout = 8'hFF;
    if (dma_wr) begin
      oam_a   = OAM_BASE + {8'h00, idx};
      oam_din = src_dout;
      oam_wr  = 1'b1;
    end else if (ppu_oam_gnt) begin
      oam_a = ppu_oam_a;
    end else if (!dma_active) begin
      oam_a        = cpu_oam_a;
      oam_din      = cpu_oam_din;
      oam_wr       = cpu_oam_wr;
      cpu_oam_dout = oam_dout;
    end
  end

endmodule
